// File: rtl/router_out_arbiter.sv
// Per-output-port round-robin arbiter. It grants one input for a whole packet.
// Optional stalled-owner timeout: define ROUTER_ARB_TIMEOUT_EN.
module router_out_arbiter #(
    parameter int N       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         frame_n,
    input  logic [N-1:0]         valid_n,
    input  logic                 busy_n,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_vld,
    output logic                 pkt_done,
    output logic                 abort
);

    localparam int IDW = $clog2(N);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_OWN  = 1'b1;

    if (N < 2 || TIMEOUT < 1) begin : g_param_check
        $error("router_out_arbiter: N must be >= 2 and TIMEOUT must be >= 1");
    end

    logic [0:0]     state;
    logic [0:0]     state_nx;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nx;
    logic [IDW-1:0] owner_inc;
    logic [IDW-1:0] search_base;
    logic [IDW-1:0] sel_id;
    logic [IDW-1:0] grant_id_nx;
    logic [N-1:0]   cand;
    logic [N-1:0]   grant_nx;
    logic           found;
    logic           take_grant;
    logic           owner_frame_n;
    logic           owner_valid_n;
    logic           release_now;
    logic           last_beat;
    logic           timeout_hit;
    logic           grant_vld_nx;
    logic           pkt_done_nx;
    logic           abort_nx;
    int             idx;

    assign owner_frame_n = frame_n[grant_id];
    assign owner_valid_n = valid_n[grant_id];
    assign owner_inc     = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);

`ifdef ROUTER_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt;
    logic          stall_cycle;

    // A stall is the owner still framing a packet but offering no beat.
    assign stall_cycle = (state == S_OWN) && owner_valid_n && !owner_frame_n;
    assign timeout_hit = stall_cycle && (idle_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || (state != S_OWN) || release_now || !stall_cycle) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // The owner lets go either by finishing its frame or by timing out.
    assign release_now = (state == S_OWN) && (owner_frame_n || timeout_hit);
    assign last_beat   = (state == S_OWN) && owner_frame_n && !owner_valid_n;

    // Round-robin search. A releasing owner is masked out so it cannot re-win at once.
    // NOTE: every combinational output gets a default before the loop, so no latch can form.
    always_comb begin
        search_base = (state == S_OWN) ? owner_inc : ptr;
        cand        = ~frame_n;
        found       = 1'b0;
        sel_id      = '0;
        idx         = 0;
        if (state == S_OWN) begin
            cand[grant_id] = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            idx = int'(search_base) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && cand[idx]) begin
                found  = 1'b1;
                sel_id = IDW'(idx);
            end
        end
    end

    assign take_grant = found && busy_n;

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        grant_nx     = grant;
        grant_id_nx  = grant_id;
        grant_vld_nx = grant_vld;
        pkt_done_nx  = 1'b0;
        abort_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                if (take_grant) begin
                    state_nx     = S_OWN;
                    grant_nx     = N'(1) << sel_id;
                    grant_id_nx  = sel_id;
                    grant_vld_nx = 1'b1;
                end
            end
            S_OWN: begin
                if (release_now) begin
                    pkt_done_nx = last_beat;
                    abort_nx    = !last_beat;
                    ptr_nx      = owner_inc;
                    if (take_grant) begin
                        grant_nx    = N'(1) << sel_id;
                        grant_id_nx = sel_id;
                    end else begin
                        state_nx     = S_IDLE;
                        grant_nx     = '0;
                        grant_id_nx  = '0;
                        grant_vld_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx     = S_IDLE;
                grant_nx     = '0;
                grant_id_nx  = '0;
                grant_vld_nx = 1'b0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments, so every register samples pre-edge values.
    // NOTE: reset is synchronous and clears every register; no pulse can leak out of a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            grant     <= '0;
            grant_id  <= '0;
            grant_vld <= 1'b0;
            pkt_done  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            grant     <= grant_nx;
            grant_id  <= grant_id_nx;
            grant_vld <= grant_vld_nx;
            pkt_done  <= pkt_done_nx;
            abort     <= abort_nx;
        end
    end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Scoreboard bench for router_out_arbiter. A behavioural model pushes expected
// outputs per cycle and a directed check covers each scenario's key point.
module tb_router_out_arbiter;

    localparam int N       = 16;
    localparam int TIMEOUT = 8;
    localparam int IDW     = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   frame_n;
    logic [N-1:0]   valid_n;
    logic           busy_n;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_vld;
    logic           pkt_done;
    logic           abort;

    router_out_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .frame_n  (frame_n),
        .valid_n  (valid_n),
        .busy_n   (busy_n),
        .grant    (grant),
        .grant_id (grant_id),
        .grant_vld(grant_vld),
        .pkt_done (pkt_done),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]   grant;
        logic [IDW-1:0] id;
        logic           vld;
        logic           done;
        logic           abort;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_stall = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input int base, input int excl);
        int res;
        int i;
        res = -1;
        for (int k = 0; k < N; k++) begin
            i = (base + k) % N;
            if (res < 0 && i != excl && !frame_n[i]) res = i;
        end
        return res;
    endfunction

    task automatic model_push();
        exp_t e;
        int   nxt;
        int   g;
        bit   rel;
        e = '0;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_stall = 0;
        end else if (m_owner < 0) begin
            if (busy_n) begin
                nxt = pick(m_ptr, -1);
                if (nxt >= 0) m_owner = nxt;
            end
        end else begin
            g   = m_owner;
            rel = frame_n[g];
`ifdef ROUTER_ARB_TIMEOUT_EN
            if (!frame_n[g] && valid_n[g]) begin
                m_stall++;
                if (m_stall == TIMEOUT) rel = 1'b1;
            end else begin
                m_stall = 0;
            end
`endif
            if (rel) begin
                e.done  = frame_n[g] && !valid_n[g];
                e.abort = !e.done;
                m_ptr   = (g + 1) % N;
                m_owner = -1;
                m_stall = 0;
                if (busy_n) begin
                    nxt = pick(m_ptr, g);
                    if (nxt >= 0) m_owner = nxt;
                end
            end
        end
        if (m_owner >= 0) begin
            e.grant = N'(1) << m_owner;
            e.id    = IDW'(m_owner);
            e.vld   = 1'b1;
        end
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("grant", 32'(grant), 32'(e.grant));
            check("grant_id", 32'(grant_id), 32'(e.id));
            check("grant_vld", 32'(grant_vld), 32'(e.vld));
            check("pkt_done", 32'(pkt_done), 32'(e.done));
            check("abort", 32'(abort), 32'(e.abort));
        end
    endtask

    task automatic step();
        model_push();
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic drive(input int i, input bit f, input bit v);
        frame_n[i] = f;
        valid_n[i] = v;
    endtask

    task automatic idle_all();
        frame_n = '1;
        valid_n = '1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_all();
        step();
        reset = 1'b0;
    endtask

    int rr_ids[3] = '{2, 7, 12};
    int rr_exp[4] = '{2, 7, 12, 2};
    int bc[N];
    int order[$];
    int gaps;
    int last_id;
    bit started;

    initial begin
        reset   = 1'b1;
        busy_n  = 1'b1;
        idle_all();

        // Reset held two cycles, then idle
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_vld", 32'(grant_vld), 32'h0);

        // Single packet from input 5, four beats
        drive(5, 0, 1);
        step();
        check("sp_grant", 32'(grant), 32'h0020);
        check("sp_id", 32'(grant_id), 32'd5);
        for (int k = 0; k < 3; k++) begin
            drive(5, 0, 0);
            step();
        end
        drive(5, 1, 0);
        step();
        check("sp_done", 32'(pkt_done), 32'd1);
        check("sp_release", 32'(grant), 32'h0);
        idle_all();
        step();

        // Round-robin among 2, 7, 12 with 3-beat packets
        do_reset();
        gaps    = 0;
        last_id = -1;
        started = 1'b0;
        for (int k = 0; k < N; k++) bc[k] = 0;
        for (int c = 0; c < 14; c++) begin
            for (int j = 0; j < 3; j++) begin
                if (m_owner == rr_ids[j]) begin
                    bc[rr_ids[j]]++;
                    if (bc[rr_ids[j]] == 3) begin
                        drive(rr_ids[j], 1, 0);
                        bc[rr_ids[j]] = 0;
                    end else begin
                        drive(rr_ids[j], 0, 0);
                    end
                end else begin
                    drive(rr_ids[j], 0, 1);
                end
            end
            step();
            if (grant_vld) begin
                started = 1'b1;
                if (int'(grant_id) != last_id) begin
                    order.push_back(int'(grant_id));
                    last_id = int'(grant_id);
                end
            end else if (started) begin
                gaps++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            check("rr_order", 32'((k < order.size()) ? order[k] : 99), 32'(rr_exp[k]));
        end
        check("rr_gaps", 32'(gaps), 32'd0);
        idle_all();
        step();
        step();

        // Backpressure before grant
        do_reset();
        busy_n = 1'b0;
        drive(3, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_nogrant", 32'(grant), 32'h0);
        end
        busy_n = 1'b1;
        step();
        check("bp_grant", 32'(grant), 32'h0008);
        // Owner 3 releases while 11 waits and the output is busy
        drive(11, 0, 1);
        drive(3, 1, 0);
        busy_n = 1'b0;
        step();
        check("bp_rel_done", 32'(pkt_done), 32'd1);
        check("bp_rel_nogrant", 32'(grant_vld), 32'd0);
        drive(3, 1, 1);
        busy_n = 1'b1;
        step();
        check("bp_next", 32'(grant), 32'h0800);
        drive(11, 1, 0);
        step();
        idle_all();
        step();

        // Abort by input 9, then the pointer lands on 10
        do_reset();
        drive(9, 0, 1);
        step();
        drive(9, 0, 0);
        step();
        drive(9, 1, 1);
        step();
        check("ab_abort", 32'(abort), 32'd1);
        check("ab_nodone", 32'(pkt_done), 32'd0);
        check("ab_grant", 32'(grant), 32'h0);
        drive(8, 0, 1);
        drive(10, 0, 1);
        step();
        check("ab_ptr10", 32'(grant), 32'h0400);

        // Reset while owning: cleared with no pulses
        reset = 1'b1;
        step();
        check("rs_grant", 32'(grant), 32'h0);
        check("rs_pulse", 32'({pkt_done, abort}), 32'h0);
        idle_all();
        reset = 1'b0;
        step();

        // Request dropped in IDLE is still granted, then aborts
        drive(4, 0, 1);
        step();
        check("dr_grant", 32'(grant), 32'h0010);
        drive(4, 1, 1);
        step();
        check("dr_abort", 32'(abort), 32'd1);

        // Single requester re-granted after a one-cycle gap
        drive(6, 0, 1);
        step();
        drive(6, 1, 0);
        step();
        drive(6, 0, 1);
        step();
        check("sr_regrant", 32'(grant), 32'h0040);
        drive(6, 1, 0);
        step();
        idle_all();
        step();

        // Stalled owner: forced release only with the timeout feature
        do_reset();
        drive(0, 0, 1);
        drive(1, 0, 1);
        step();
`ifdef ROUTER_ARB_TIMEOUT_EN
        for (int k = 0; k < TIMEOUT; k++) step();
        check("to_abort", 32'(abort), 32'd1);
        check("to_next", 32'(grant), 32'h0002);
`else
        for (int k = 0; k < TIMEOUT + 4; k++) step();
        check("to_hold", 32'(grant), 32'h0001);
        check("to_noabort", 32'(abort), 32'd0);
`endif
        idle_all();
        step();
        step();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
